// File: rtl/writeback_regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : writeback_regfile_if                                          |
// | Purpose  : Bundles the MEM/WB inputs, the decode read ports and the      |
// |            write-back bus exported to the forwarding unit.               |
// | Modports : master - pipeline side (drives MEM/WB fields, read addresses) |
// |            slave  - register file side (drives read data, wb bus, count) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface writeback_regfile_if #(
  parameter int XLEN = 32
);
  // MEM/WB pipeline register fields
  logic [XLEN-1:0] mem_data_in;
  logic [XLEN-1:0] alu_result_in;
  logic [4:0]      rd_in;
  logic            reg_write_in;
  logic            mem_to_reg_in;

  // Decode-stage read ports
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  // Write-back bus towards the forwarding unit
  logic [XLEN-1:0] wb_data_out;
  logic [4:0]      wb_rd_out;
  logic            wb_en_out;

  // Committed-write counter
  logic [31:0]     wb_count;

  modport master (
    output mem_data_in, alu_result_in, rd_in, reg_write_in, mem_to_reg_in,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data,
    input  wb_data_out, wb_rd_out, wb_en_out,
    input  wb_count
  );

  modport slave (
    input  mem_data_in, alu_result_in, rd_in, reg_write_in, mem_to_reg_in,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data,
    output wb_data_out, wb_rd_out, wb_en_out,
    output wb_count
  );
endinterface
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : writeback_regfile                                             |
// | Purpose  : RV32I write-back stage and 32 x XLEN architectural register   |
// |            file. Selects load data or ALU result, commits it to rd,      |
// |            serves two combinational decode read ports, exports the       |
// |            write-back bus and counts committed register writes.          |
// | Ports    : clk   - pipeline clock, rising-edge state updates             |
// |            reset - asynchronous, active-low reset                        |
// |            wb    - writeback_regfile_if.slave (MEM/WB inputs, rs1/rs2    |
// |                    read ports, wb_data_out/wb_rd_out/wb_en_out bus and   |
// |                    wb_count)                                             |
// | Options  : REGFILE_BYPASS_EN - when defined, a read of the register being |
// |            committed this cycle returns the new value (write-first).     |
// |            When undefined, reads return stored contents only.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  writeback_regfile_if.slave wb
);

  localparam int ADDR_W = 5;

  // ---------------------------------------------------------------------
  // Write-back selection and effective enable
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] w_wb_data;
  logic            w_wb_en;

  // The mux is independent of reg_write_in so the forwarding unit always
  // sees the candidate value.
  assign w_wb_data = wb.mem_to_reg_in ? wb.mem_data_in : wb.alu_result_in;

  // x0 is hard-wired to zero: a write aimed at it is not a real commit.
  assign w_wb_en   = wb.reg_write_in && (wb.rd_in != '0);

  assign wb.wb_data_out = w_wb_data;
  assign wb.wb_rd_out   = wb.rd_in;
  assign wb.wb_en_out   = w_wb_en;

  // ---------------------------------------------------------------------
  // Register array x1..x31 (x0 has no storage)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] r_regs   [1:NREGS-1];
  logic [XLEN-1:0] w_rd_tbl [0:NREGS-1];

  assign w_rd_tbl[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_regs
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_regs[i] <= '0;
      end else if (w_wb_en && (wb.rd_in == ADDR_W'(i))) begin
        r_regs[i] <= w_wb_data;
      end
    end

    assign w_rd_tbl[i] = r_regs[i];
  end

  // ---------------------------------------------------------------------
  // Committed-write counter (wraps silently)
  // ---------------------------------------------------------------------
  logic [31:0] r_wb_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_count <= '0;
    end else if (w_wb_en) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign wb.wb_count = r_wb_count;

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  always_comb begin
    w_rs1_data = w_rd_tbl[wb.rs1_addr];
    w_rs2_data = w_rd_tbl[wb.rs2_addr];
`ifdef REGFILE_BYPASS_EN
    // Write-first: w_wb_en already excludes x0, so address 0 still reads 0.
    if (w_wb_en && (wb.rs1_addr == wb.rd_in)) begin
      w_rs1_data = w_wb_data;
    end
    if (w_wb_en && (wb.rs2_addr == wb.rd_in)) begin
      w_rs2_data = w_wb_data;
    end
`endif
  end

  assign wb.rs1_data = w_rs1_data;
  assign wb.rs2_data = w_rs2_data;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_writeback_regfile                                          |
// | Purpose  : Directed self-checking bench for writeback_regfile. Expected  |
// |            values are queued when stimulus is applied and popped when    |
// |            the corresponding DUT output is sampled.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_writeback_regfile;

  logic clk;
  logic reset;

  writeback_regfile_if #(.XLEN(32)) bus ();

  writeback_regfile #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  int          n_checks;
  int          n_fail;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Advance past the next rising edge, sampling away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic m2r,
                       input logic [31:0] mem, input logic [31:0] alu);
    bus.reg_write_in  = we;
    bus.rd_in         = rd;
    bus.mem_to_reg_in = m2r;
    bus.mem_data_in   = mem;
    bus.alu_result_in = alu;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

    // Reset held: a write attempt is ignored.
    #1;
    drive(1'b1, 5'd5, 1'b0, 32'h0, 32'h5555);
    tick();
    drive(1'b0, 5'd5, 1'b0, 32'h0, 32'h0);
    bus.rs1_addr = 5'd5;
    push(32'h0); push(32'h0);
    #1;
    check("rst_count", bus.wb_count);
    check("rst_x5", bus.rs1_data);
    reset = 1'b1;
    tick();

    // Write x5 = 0x1234; wb bus is zero-latency.
    drive(1'b1, 5'd5, 1'b0, 32'hFFFF_0000, 32'h1234);
    push(32'h1234); push(32'd5); push(32'd1);
    #1;
    check("wb_data", bus.wb_data_out);
    check("wb_rd", {27'd0, bus.wb_rd_out});
    check("wb_en", {31'd0, bus.wb_en_out});
    tick();
    drive(1'b0, 5'd5, 1'b0, 32'h0, 32'h0);
    push(32'h1234); push(32'd1);
    #1;
    check("x5_commit", bus.rs1_data);
    check("count_1", bus.wb_count);

    // Asynchronous reset between edges.
    #1 reset = 1'b0;
    push(32'h0); push(32'h0);
    #1;
    check("async_rst_x5", bus.rs1_data);
    check("async_rst_count", bus.wb_count);
    @(negedge clk);
    reset = 1'b1;

    // Edge 1: load data selected.
    drive(1'b1, 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h11);
    tick();
    drive(1'b0, 5'd3, 1'b1, 32'h0, 32'h0);
    bus.rs2_addr = 5'd3;
    push(32'hDEAD_BEEF);
    #1;
    check("x3_load", bus.rs2_data);

    // Edge 2: ALU result selected.
    drive(1'b1, 5'd3, 1'b0, 32'hDEAD_BEEF, 32'h11);
    tick();
    drive(1'b0, 5'd3, 1'b0, 32'h0, 32'h0);
    push(32'h11); push(32'd2);
    #1;
    check("x3_alu", bus.rs2_data);
    check("count_2", bus.wb_count);

    // x0 protection.
    drive(1'b1, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    bus.rs1_addr = 5'd0;
    push(32'd0); push(32'h0);
    #1;
    check("x0_wb_en", {31'd0, bus.wb_en_out});
    check("x0_read_pre", bus.rs1_data);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    push(32'h0); push(32'd2);
    #1;
    check("x0_read_post", bus.rs1_data);
    check("x0_count", bus.wb_count);

    // Same-cycle read of the write target.
    drive(1'b1, 5'd7, 1'b0, 32'h0, 32'hA);
    tick();
    drive(1'b1, 5'd7, 1'b0, 32'h0, 32'hB);
    bus.rs1_addr = 5'd7;
    push(BYPASS ? 32'hB : 32'hA);
    #1;
    check("x7_same_cycle", bus.rs1_data);
    tick();
    drive(1'b0, 5'd7, 1'b0, 32'h0, 32'h0);
    push(32'hB); push(32'd4);
    #1;
    check("x7_after", bus.rs1_data);
    check("count_4", bus.wb_count);

    // Disabled write.
    drive(1'b0, 5'd9, 1'b0, 32'h0, 32'h55);
    bus.rs2_addr = 5'd9;
    push(32'h55); push(32'd0); push(32'h0);
    #1;
    check("dis_wb_data", bus.wb_data_out);
    check("dis_wb_en", {31'd0, bus.wb_en_out});
    check("dis_x9_pre", bus.rs2_data);
    tick();
    push(32'h0); push(32'd4);
    #1;
    check("dis_x9_post", bus.rs2_data);
    check("dis_count", bus.wb_count);

    // Both ports on the register being written.
    drive(1'b1, 5'd3, 1'b1, 32'h77, 32'h0);
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd3;
    push(BYPASS ? 32'h77 : 32'h11);
    push(BYPASS ? 32'h77 : 32'h11);
    #1;
    check("dual_rs1", bus.rs1_data);
    check("dual_rs2", bus.rs2_data);
    tick();
    drive(1'b0, 5'd3, 1'b0, 32'h0, 32'h0);
    push(32'h77); push(32'h77); push(32'd5);
    #1;
    check("dual_rs1_post", bus.rs1_data);
    check("dual_rs2_post", bus.rs2_data);
    check("count_5", bus.wb_count);

    // Counter wrap.
    drive(1'b1, 5'd10, 1'b0, 32'h0, 32'h99);
    force dut.r_wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wb_count;
    push(32'hFFFF_FFFF);
    #1;
    check("count_preload", bus.wb_count);
    tick();
    drive(1'b0, 5'd10, 1'b0, 32'h0, 32'h0);
    bus.rs1_addr = 5'd10;
    push(32'h0); push(32'h99);
    #1;
    check("count_wrap", bus.wb_count);
    check("x10_commit", bus.rs1_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and architectural register file for the 5-stage RV32I pipeline. The block consumes the MEM/WB pipeline register outputs and selects the write-back value: loaded data or ALU result. It commits that value into a 32×32 integer register file and serves the two decode-stage read ports. It also exports the write-back bus to the forwarding unit and keeps a free-running count of committed register writes.

## Interface
Parameters:
- XLEN, 32, data width of registers and buses
- NREGS, 32, number of architectural registers; fixed at 32, with 5-bit addresses

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- mem_data_in  input  XLEN  load data from MEM/WB
- alu_result_in  input  XLEN  ALU result from MEM/WB
- rd_in  input  5  destination register from MEM/WB
- reg_write_in  input  1  write enable from MEM/WB
- mem_to_reg_in  input  1  1 selects mem_data_in, 0 selects alu_result_in
- rs1_addr  input  5  decode read port 1 address
- rs2_addr  input  5  decode read port 2 address
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_data  output  XLEN  read port 2 data (combinational)
- wb_data_out  output  XLEN  selected write-back value (combinational, to forwarding unit)
- wb_rd_out  output  5  equals rd_in
- wb_en_out  output  1  effective write enable: reg_write_in AND (rd_in != 0)
- wb_count  output  32  number of committed register writes since reset

## Operation
- Write-back mux: wb_data_out = mem_to_reg_in ? mem_data_in : alu_result_in. This is purely combinational and does not depend on reg_write_in.
- Commit: on the rising edge of clk with wb_en_out = 1, regs[rd_in] <= wb_data_out.
- x0: never written. Writes to rd_in = 0 are dropped silently, and reads of address 0 always return 0.
- Reads: combinational. rsN_data = regs[rsN_addr], with x0 forced to 0, subject to the bypass in Configuration.
- Counter: wb_count increments by 1 on each rising edge where wb_en_out = 1.
  - Dropped x0 writes and cycles with reg_write_in = 0 do not count.
  - The counter wraps 0xFFFFFFFF → 0 with no flag.
- There is no stall or flush input. Upstream squashes an instruction by presenting reg_write_in = 0. The block holds no pipeline state other than the register array and the counter.
- There is no state machine. Sequential state is the register array (31 × XLEN) plus wb_count.

## Timing
- Reset asserted (reset = 0): all registers x1..x31 and wb_count clear to 0 immediately, without waiting for a clock edge.
- Reset held low: writes are ignored and the counter stays at 0. rs1_data and rs2_data read 0 for every address, except that with bypass enabled they may also show the bypassed wb_data_out.
- Reset deassertion: the first commit occurs at the first rising edge after reset returns high.
- Reset mid-operation: a write whose edge coincides with reset low is lost.
- Commit latency: the value is visible from stored state in the cycle after the edge. With bypass enabled, it is also visible combinationally in the same cycle.
- Both read ports addressing the write-back rd in the same cycle: both ports see identical data.
- wb_data_out, wb_rd_out and wb_en_out have zero latency from the inputs.

## Configuration
- REGFILE_BYPASS_EN defined: write-first bypass is compiled in.
  - Rule: if wb_en_out = 1 and rsN_addr == rd_in, then rsN_data = wb_data_out in the same cycle.
  - Effect: the decode stage needs no stall for a WB→ID dependency.
- REGFILE_BYPASS_EN undefined: reads return stored contents only, i.e. the pre-write value in the commit cycle.
  - Requirement: the hazard unit must insert one extra stall for a WB→ID dependency.
- With or without the macro, all other behaviour is identical.

## Test plan
- Reset: write x5 = 0x1234 and clock it in, then drive reset = 0 between clock edges → rs1_data for x5 reads 0 immediately and wb_count = 0.
- Mux and commit:
  - Edge 1: rd_in = 3, reg_write_in = 1, mem_to_reg_in = 1, mem_data_in = 0xDEADBEEF, alu_result_in = 0x11 → after the edge, rs2_addr = 3 reads 0xDEADBEEF.
  - Edge 2: mem_to_reg_in = 0 → x3 becomes 0x11 and wb_count = 2.
- x0 protection: rd_in = 0, reg_write_in = 1, alu_result_in = 0xFFFFFFFF → wb_en_out = 0, rs1_addr = 0 reads 0, and wb_count is unchanged.
- Same-cycle read of write target: x7 holds 0xA, and the current cycle writes 0xB to x7 with rs1_addr = 7 →
  - with REGFILE_BYPASS_EN, rs1_data = 0xB before the edge;
  - without it, rs1_data = 0xA before the edge;
  - in both builds, rs1_data = 0xB after the edge.
- Disabled write: reg_write_in = 0, rd_in = 9, data 0x55 → x9 is unchanged, wb_count is unchanged, and wb_data_out still equals 0x55.
- Counter wrap: preload wb_count to 0xFFFFFFFF via hierarchical force, then do one valid write → wb_count = 0.
